// File: rtl/mc_seq_ctrl_pkg.sv
// mc_seq_ctrl_pkg: shared types and constants for the multicycle sequencer.
//   mc_state_t    - sequencer state encoding
//   trap_cause_t  - trap cause code driven on trap_cause
//   OPC_*         - RV32I major opcode constants
//   is_legal_op() - 1 when the opcode is one the core implements
package mc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    F_WAIT = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    M_WAIT = 3'd5,
    WB     = 3'd6,
    TRAP   = 3'd7
  } mc_state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_BUS_TO  = 2'd2
  } trap_cause_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// mc_seq_ctrl_if: shared instruction/data memory port.
//   mem_req      master->slave  request, held with mem_we/mem_addr_sel stable until mem_gnt
//   mem_we       master->slave  1 = write (store data phase)
//   mem_addr_sel master->slave  0 = PC, 1 = ALU result
//   mem_gnt      slave->master  request accepted in this cycle
//   mem_rvalid   slave->master  read data valid / write acknowledge
// Handshake: a request is accepted in the cycle where mem_req && mem_gnt;
// completion is the first mem_rvalid in or after that cycle. Responses seen
// while no request is outstanding are ignored by the master.
interface mc_seq_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_gnt;
  logic mem_rvalid;

  modport master (output mem_req, output mem_we, output mem_addr_sel,
                  input  mem_gnt, input  mem_rvalid);
  modport slave  (input  mem_req, input  mem_we, input  mem_addr_sel,
                  output mem_gnt, output mem_rvalid);
endinterface

// File: rtl/mc_seq_ctrl_timeout_cnt.sv
// mc_timeout_cnt: wait-cycle counter for the memory response timeout.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       synchronous clear (priority over i_en)
//   i_en        increment
//   o_expired   counter has reached TIMEOUT_CYCLES-1
module mc_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_expired = (r_cnt == LIMIT);
endmodule

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multicycle sequencer (FETCH/DECODE/EXEC/MEM/WB) for the
// simplified RISC-V core, sharing one memory port for fetch and data.
//   clk, rst_n    clock, asynchronous active-low reset
//   run           allow a new fetch (looked at only in FETCH)
//   opcode        opcode of the latched IR
//   reg_wen_dec   register write enable from the control decoder
//   bus           memory port (mc_seq_ctrl_if.master)
//   ir_wen, mdr_wen, rf_wen, pc_wen  datapath strobes
//   retire        one-cycle pulse per completed instruction
//   busy          not idle in FETCH
//   trap, trap_cause  sticky trap and its cause
//   o_dbg_state   current sequencer state
// Optional: MC_INSTRET_CNT_EN adds instret_clr / instret (64-bit retire count).
// Outputs are state decodes; ir_wen/mdr_wen additionally need mem_rvalid.
// In FETCH, mem_req follows run (or a pending un-granted request).
module mc_seq_ctrl
  import mc_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        reg_wen_dec,
  mc_seq_ctrl_if.master bus,
  output logic        ir_wen,
  output logic        mdr_wen,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        retire,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output mc_state_t   o_dbg_state
`ifdef MC_INSTRET_CNT_EN
  ,
  input  logic        instret_clr,
  output logic [63:0] instret
`endif
);

  mc_state_t   r_state, w_next;
  trap_cause_t r_cause, w_cause_nxt;
  logic        r_req_pend;
  logic        w_req, w_we, w_addr_sel;
  logic        w_ir_wen, w_mdr_wen, w_rf_wen, w_pc_wen, w_retire;
  logic        w_cnt_clr, w_cnt_en, w_expired;
  logic        w_is_load, w_is_store;

  assign w_is_load  = (opcode == OPC_LOAD);
  assign w_is_store = (opcode == OPC_STORE);

  mc_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_cause    <= TC_NONE;
      r_req_pend <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cause    <= w_cause_nxt;
      // Keeps a fetch request alive if run drops before the grant.
      r_req_pend <= (r_state == FETCH) && w_req && !bus.mem_gnt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cause_nxt = r_cause;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_addr_sel  = 1'b0;
    w_ir_wen    = 1'b0;
    w_mdr_wen   = 1'b0;
    w_rf_wen    = 1'b0;
    w_pc_wen    = 1'b0;
    w_retire    = 1'b0;
    w_cnt_clr   = 1'b1;
    w_cnt_en    = 1'b0;
    case (r_state)
      FETCH: begin
        w_req = run || r_req_pend;
        if (w_req && bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            w_ir_wen = 1'b1;
            w_next   = DECODE;
          end else begin
            w_next   = F_WAIT;
          end
        end
      end
      F_WAIT: begin
        w_cnt_clr = 1'b0;
        // rvalid in the limit cycle still completes the fetch.
        if (bus.mem_rvalid) begin
          w_ir_wen  = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = DECODE;
        end else if (w_expired) begin
          w_cause_nxt = TC_BUS_TO;
          w_next      = TRAP;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DECODE: begin
        if (is_legal_op(opcode)) begin
          w_next = EXEC;
        end else begin
          w_cause_nxt = TC_ILLEGAL;
          w_next      = TRAP;
        end
      end
      EXEC: w_next = (w_is_load || w_is_store) ? MEM : WB;
      MEM: begin
        w_req      = 1'b1;
        w_addr_sel = 1'b1;
        w_we       = w_is_store;
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            w_mdr_wen = w_is_load;
            w_next    = WB;
          end else begin
            w_next    = M_WAIT;
          end
        end
      end
      M_WAIT: begin
        w_cnt_clr = 1'b0;
        if (bus.mem_rvalid) begin
          w_mdr_wen = w_is_load;
          w_cnt_clr = 1'b1;
          w_next    = WB;
        end else if (w_expired) begin
          w_cause_nxt = TC_BUS_TO;
          w_next      = TRAP;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      WB: begin
        w_rf_wen = reg_wen_dec;
        w_pc_wen = 1'b1;
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

  assign bus.mem_req      = w_req;
  assign bus.mem_we       = w_we;
  assign bus.mem_addr_sel = w_addr_sel;
  assign ir_wen           = w_ir_wen;
  assign mdr_wen          = w_mdr_wen;
  assign rf_wen           = w_rf_wen;
  assign pc_wen           = w_pc_wen;
  assign retire           = w_retire;
  assign busy             = (r_state != FETCH) || w_req;
  assign trap             = (r_state == TRAP);
  assign trap_cause       = r_cause;
  assign o_dbg_state      = r_state;

`ifdef MC_INSTRET_CNT_EN
  logic [63:0] r_instret;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_instret <= '0;
    else if (instret_clr) r_instret <= '0;
    else if (w_retire)    r_instret <= r_instret + 64'd1;
  end
  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: directed bench for mc_seq_ctrl (TIMEOUT_CYCLES = 16).
// Inputs change 2 time units after the rising edge; outputs are checked
// 1 unit later, well away from the next edge.
module tb_mc_seq_ctrl;
  import mc_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic        reg_wen_dec = 1'b0;
  logic        ir_wen, mdr_wen, rf_wen, pc_wen, retire, busy, trap;
  logic [1:0]  trap_cause;
  mc_state_t   dbg_state;
  int          n_checks = 0;
  int          n_errors = 0;
`ifdef MC_INSTRET_CNT_EN
  logic        instret_clr = 1'b0;
  logic [63:0] instret;
`endif

  mc_seq_ctrl_if bus_if();

  mc_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .reg_wen_dec(reg_wen_dec),
    .bus        (bus_if.master),
    .ir_wen     (ir_wen),
    .mdr_wen    (mdr_wen),
    .rf_wen     (rf_wen),
    .pc_wen     (pc_wen),
    .retire     (retire),
    .busy       (busy),
    .trap       (trap),
    .trap_cause (trap_cause),
    .o_dbg_state(dbg_state)
`ifdef MC_INSTRET_CNT_EN
    ,
    .instret_clr(instret_clr),
    .instret    (instret)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic r, input logic g, input logic v);
    run              = r;
    bus_if.mem_gnt    = g;
    bus_if.mem_rvalid = v;
  endtask

  initial begin
    mc_state_t add_seq [4];
    add_seq = '{FETCH, DECODE, EXEC, WB};
    set_bus(1'b0, 1'b0, 1'b0);

    // reset state
    #1;
    chk("rst_state", dbg_state, FETCH);
    chk("rst_req", bus_if.mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_cause", trap_cause, 2'd0);
    chk("rst_retire", retire, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // zero-wait ADD: retire every 4 cycles, rf/pc writes only in WB
    opcode = 7'h33; reg_wen_dec = 1'b1;
    set_bus(1'b1, 1'b1, 1'b1);
    #1;
    chk("add_req", bus_if.mem_req, 1'b1);
    chk("add_asel", bus_if.mem_addr_sel, 1'b0);
    chk("add_irw", ir_wen, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) #1;
      chk("add_state", dbg_state, add_seq[i % 4]);
      chk("add_retire", retire, (i % 4) == 3);
      chk("add_rfw", rf_wen, (i % 4) == 3);
      chk("add_pcw", pc_wen, (i % 4) == 3);
      tick();
    end
    set_bus(1'b0, 1'b0, 1'b0);
    #1;
    chk("idle_state", dbg_state, FETCH);
    chk("idle_req", bus_if.mem_req, 1'b0);
    chk("idle_busy", busy, 1'b0);
    tick();

    // LOAD: data request held until grant, rvalid 3 cycles after grant
    opcode = 7'h03;
    set_bus(1'b1, 1'b1, 1'b1);
    #1;
    chk("ld_irw", ir_wen, 1'b1);
    tick(); tick(); tick();
    set_bus(1'b1, 1'b0, 1'b0);
    #1;
    chk("ld_mem_state", dbg_state, MEM);
    chk("ld_req", bus_if.mem_req, 1'b1);
    chk("ld_asel", bus_if.mem_addr_sel, 1'b1);
    chk("ld_we", bus_if.mem_we, 1'b0);
    tick();
    #1;
    chk("ld_hold_state", dbg_state, MEM);
    chk("ld_hold_req", bus_if.mem_req, 1'b1);
    chk("ld_hold_asel", bus_if.mem_addr_sel, 1'b1);
    bus_if.mem_gnt = 1'b1;
    tick();
    bus_if.mem_gnt = 1'b0;
    #1;
    chk("ld_mwait", dbg_state, M_WAIT);
    chk("ld_mwait_req", bus_if.mem_req, 1'b0);
    chk("ld_mdr_w1", mdr_wen, 1'b0);
    tick();
    #1;
    chk("ld_mdr_w2", mdr_wen, 1'b0);
    tick();
    bus_if.mem_rvalid = 1'b1;
    #1;
    chk("ld_mdr_pulse", mdr_wen, 1'b1);
    chk("ld_no_retire", retire, 1'b0);
    tick();
    set_bus(1'b0, 1'b0, 1'b0);
    #1;
    chk("ld_wb_state", dbg_state, WB);
    chk("ld_retire", retire, 1'b1);
    chk("ld_rfw", rf_wen, 1'b1);
    chk("ld_mdr_off", mdr_wen, 1'b0);
    tick();

    // STORE: write phase, no MDR load, decoder drives reg_wen_dec=0
    opcode = 7'h23; reg_wen_dec = 1'b0;
    set_bus(1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    #1;
    chk("st_state", dbg_state, MEM);
    chk("st_we", bus_if.mem_we, 1'b1);
    chk("st_asel", bus_if.mem_addr_sel, 1'b1);
    chk("st_mdr", mdr_wen, 1'b0);
    tick();
    run = 1'b0;
    #1;
    chk("st_wb", dbg_state, WB);
    chk("st_rfw", rf_wen, 1'b0);
    chk("st_pcw", pc_wen, 1'b1);
    chk("st_retire", retire, 1'b1);
    chk("st_mdr_wb", mdr_wen, 1'b0);
    tick();

    // fetch rvalid in the 16th wait cycle: completes, no trap
    opcode = 7'h33; reg_wen_dec = 1'b1;
    set_bus(1'b1, 1'b1, 1'b0);
    tick();
    set_bus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk("to16_wait", dbg_state, F_WAIT);
      tick();
    end
    bus_if.mem_rvalid = 1'b1;
    #1;
    chk("to16_state", dbg_state, F_WAIT);
    chk("to16_irw", ir_wen, 1'b1);
    tick();
    bus_if.mem_rvalid = 1'b0;
    #1;
    chk("to16_decode", dbg_state, DECODE);
    chk("to16_trap", trap, 1'b0);
    tick(); tick(); tick();
    #1;
    chk("to16_fetch", dbg_state, FETCH);

    // illegal opcode
    opcode = 7'h7F;
    set_bus(1'b1, 1'b1, 1'b1);
    tick();
    #1;
    chk("ill_decode", dbg_state, DECODE);
    tick();
    #1;
    chk("ill_state", dbg_state, TRAP);
    chk("ill_trap", trap, 1'b1);
    chk("ill_cause", trap_cause, 2'd1);
    chk("ill_irw", ir_wen, 1'b0);
    tick(); tick();
    #1;
    chk("ill_noreq", bus_if.mem_req, 1'b0);
    chk("ill_sticky", trap, 1'b1);

    set_bus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst2_trap", trap, 1'b0);
    chk("rst2_cause", trap_cause, 2'd0);
    chk("rst2_state", dbg_state, FETCH);
    tick();
    rst_n = 1'b1;

    // fetch timeout: TRAP 16 cycles after grant
    opcode = 7'h33;
    set_bus(1'b1, 1'b1, 1'b0);
    tick();
    set_bus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("to_wait", dbg_state, F_WAIT);
      tick();
    end
    #1;
    chk("to_state", dbg_state, TRAP);
    chk("to_trap", trap, 1'b1);
    chk("to_cause", trap_cause, 2'd2);
    set_bus(1'b1, 1'b1, 1'b1);
    tick();
    #1;
    chk("to_stay", dbg_state, TRAP);
    chk("to_noreq", bus_if.mem_req, 1'b0);
    chk("to_noirw", ir_wen, 1'b0);

    set_bus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst3_cause", trap_cause, 2'd0);
    tick();
    rst_n = 1'b1;

    // reset while in M_WAIT
    opcode = 7'h03;
    set_bus(1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    bus_if.mem_rvalid = 1'b0;
    tick();
    set_bus(1'b0, 1'b0, 1'b1);
    #1;
    chk("mw_state", dbg_state, M_WAIT);
    chk("mw_mdr", mdr_wen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mwr_state", dbg_state, FETCH);
    chk("mwr_mdr", mdr_wen, 1'b0);
    chk("mwr_req", bus_if.mem_req, 1'b0);
    chk("mwr_busy", busy, 1'b0);
    chk("mwr_retire", retire, 1'b0);
    tick();
    rst_n = 1'b1;
    set_bus(1'b1, 1'b0, 1'b0);
    #1;
    chk("post_req", bus_if.mem_req, 1'b1);
    chk("post_asel", bus_if.mem_addr_sel, 1'b0);
    chk("post_busy", busy, 1'b1);
`ifdef MC_INSTRET_CNT_EN
    chk("post_instret", instret, 64'd0);
`endif
    tick();
    run = 1'b0;
    #1;
    chk("hold_state", dbg_state, FETCH);
    chk("hold_req", bus_if.mem_req, 1'b1);
    bus_if.mem_gnt = 1'b1;
    tick();
    bus_if.mem_gnt = 1'b0;
    #1;
    chk("hold_fwait", dbg_state, F_WAIT);
    chk("hold_fwait_req", bus_if.mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
